// File: rtl/cache_index_monitor_if.sv
// Bundles the index-monitor stimulus and result signals between the cache
// control logic (master) and the cache_index_monitor block (slave).
interface cache_index_monitor_if #(
    parameter int WID  = 9,
    parameter int WAYS = 4
);
    localparam int LOG_WAYS = $clog2(WAYS);

    logic                ce;
    logic                lfsr_ce;
    logic                cyc;
    logic [WID-1:0]      i;
    logic                cd;
    logic                cd_d1;
    logic                cd_first;
    logic [16:0]         lfsr_o;
    logic [LOG_WAYS-1:0] rway;

    modport master (
        output ce, lfsr_ce, cyc, i,
        input  cd, cd_d1, cd_first, lfsr_o, rway
    );

    modport slave (
        input  ce, lfsr_ce, cyc, i,
        output cd, cd_d1, cd_first, lfsr_o, rway
    );
endinterface

// File: rtl/cache_index_monitor.sv
// L1 data cache support block: set-index change detector with a delayed
// flag and first-cycle pulse for victim dump qualification, plus a 17-bit
// XNOR LFSR that supplies the replacement way.
module cache_index_monitor #(
    parameter int WID  = 9,
    parameter int WAYS = 4
) (
    input logic                  clk,
    input logic                  rst,
    cache_index_monitor_if.slave bus
);
    localparam int LOG_WAYS = $clog2(WAYS);

    logic [WID-1:0] r_hold;
    logic           r_cd_d1;
    logic           r_cd_d2;
    logic [16:0]    r_lfsr;

    logic           w_cd;
    logic           w_cd_first;
    logic           w_fb;

    // Index differs from the last captured value; independent of ce so a
    // stalled stage keeps reporting the pending change.
    assign w_cd       = (bus.i != r_hold);
    assign w_cd_first = r_cd_d1 & ~r_cd_d2;

    // XNOR feedback on taps 17 and 14: all-zero is a legal state, so the
    // register can be cleared to 0 and all-ones becomes the lockup state.
    assign w_fb = ~(r_lfsr[16] ^ r_lfsr[13]);

    // Capture the index and the delayed change flag only on enabled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold  <= '0;
            r_cd_d1 <= 1'b0;
        end else if (bus.ce) begin
            r_hold  <= bus.i;
            r_cd_d1 <= w_cd;
        end
    end

    // Second delay runs every cycle so the first-cycle pulse stays one
    // clock wide even while ce is stalling the delay stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cd_d2 <= 1'b0;
        end else begin
            r_cd_d2 <= r_cd_d1;
        end
    end

    // LFSR: restart request beats the step enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= '0;
        end else if (bus.cyc) begin
            r_lfsr <= '0;
        end else if (bus.lfsr_ce) begin
            r_lfsr <= {r_lfsr[15:0], w_fb};
        end
    end

    assign bus.cd       = w_cd;
    assign bus.cd_d1    = r_cd_d1;
    assign bus.cd_first = w_cd_first;
    assign bus.lfsr_o   = r_lfsr;
    assign bus.rway     = r_lfsr[LOG_WAYS-1:0];
endmodule

// File: tb/tb_cache_index_monitor.sv
// Bench for cache_index_monitor: vector table for the change-detect path,
// LFSR sequence checks, randomized run against a reference model, and an
// asynchronous reset sequence.
module tb_cache_index_monitor;
    localparam int WID  = 9;
    localparam int WAYS = 4;

    logic clk;
    logic rst;

    cache_index_monitor_if #(.WID(WID), .WAYS(WAYS)) bus ();

    cache_index_monitor #(.WID(WID), .WAYS(WAYS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    typedef struct {
        logic           ce;
        logic [WID-1:0] i;
        logic           cd;
        logic           cd_d1;
        logic           cd_first;
    } vec_t;

    vec_t tbl[$];

    // Reference model state. The LFSR is modelled as the generated bit
    // stream: each new bit is the XNOR of the bits 17 and 14 positions
    // back, and the visible state is the window of the last 17 bits.
    bit             lq[$];
    logic [WID-1:0] m_hold;
    logic           m_d1;
    logic           m_d1_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        lq.delete();
        repeat (17) lq.push_back(1'b0);
    endtask

    task automatic m_step();
        bit nb;
        nb = ~(lq[lq.size()-17] ^ lq[lq.size()-14]);
        lq.push_back(nb);
        void'(lq.pop_front());
    endtask

    function automatic logic [16:0] m_state();
        logic [16:0] s;
        for (int k = 0; k < 17; k++) s[k] = lq[lq.size()-1-k];
        return s;
    endfunction

    task automatic add(input logic ce, input logic [WID-1:0] i,
                       input logic cd, input logic d1, input logic f);
        vec_t v;
        v.ce = ce; v.i = i; v.cd = cd; v.cd_d1 = d1; v.cd_first = f;
        tbl.push_back(v);
    endtask

    // Reset asserted and released away from clock edges; ends at edge+2.
    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        m_clear();
        m_hold = '0; m_d1 = 1'b0; m_d1_last = 1'b0;
    endtask

    initial begin
        logic [16:0] exp_s;
        int          period;
        bit          saw_ones;

        n_vec = 0; n_bad = 0;
        rst = 1'b1;
        bus.ce = 1'b1; bus.lfsr_ce = 1'b0; bus.cyc = 1'b0; bus.i = '0;
        m_clear();
        @(posedge clk); #2;

        // Reset state: outputs cleared, cd compares against zeroed hold.
        rst = 1'b0; bus.i = 9'h003;
        #1;
        check("rst_cd", 32'(bus.cd), 32'd1);
        check("rst_cd_d1", 32'(bus.cd_d1), 32'd0);
        check("rst_cd_first", 32'(bus.cd_first), 32'd0);
        check("rst_lfsr", 32'(bus.lfsr_o), 32'd0);
        check("rst_rway", 32'(bus.rway), 32'd0);
        bus.i = '0;
        do_reset();

        // Change-detect vector table.
        for (int k = 0; k < 10; k++) add(1, 9'h000, 0, 0, 0);
        add(1, 9'h1A5, 1, 0, 0);
        add(1, 9'h1A5, 0, 1, 1);
        add(1, 9'h1A5, 0, 0, 0);
        add(1, 9'h001, 1, 0, 0);
        add(1, 9'h002, 1, 1, 1);
        add(1, 9'h003, 1, 1, 0);
        add(1, 9'h004, 1, 1, 0);
        add(1, 9'h004, 0, 1, 0);
        add(1, 9'h004, 0, 0, 0);
        add(1, 9'h000, 1, 0, 0);
        add(1, 9'h000, 0, 1, 1);
        add(1, 9'h000, 0, 0, 0);
        add(0, 9'h010, 1, 0, 0);
        add(0, 9'h010, 1, 0, 0);
        add(1, 9'h010, 1, 0, 0);
        add(1, 9'h010, 0, 1, 1);
        add(1, 9'h010, 0, 0, 0);
        add(1, 9'h020, 1, 0, 0);
        add(0, 9'h020, 0, 1, 1);
        add(0, 9'h020, 0, 1, 0);
        add(1, 9'h020, 0, 1, 0);
        add(1, 9'h020, 0, 0, 0);

        foreach (tbl[k]) begin
            bus.ce = tbl[k].ce; bus.i = tbl[k].i;
            #1;
            check($sformatf("tbl%0d_cd", k), 32'(bus.cd), 32'(tbl[k].cd));
            check($sformatf("tbl%0d_cd_d1", k), 32'(bus.cd_d1), 32'(tbl[k].cd_d1));
            check($sformatf("tbl%0d_cd_first", k), 32'(bus.cd_first), 32'(tbl[k].cd_first));
            @(posedge clk); #2;
        end

        // LFSR start-up sequence from reset.
        bus.ce = 1'b1; bus.i = '0;
        do_reset();
        bus.lfsr_ce = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #2;
            m_step();
            exp_s = (k == 15) ? 17'h07FFE : 17'((32'd1 << k) - 1);
            check($sformatf("lfsr_step%0d", k), 32'(bus.lfsr_o), 32'(exp_s));
            check($sformatf("rway_step%0d", k), 32'(bus.rway), 32'(exp_s[1:0]));
        end

        // Longer run against the bit-stream model; lockup state must not appear.
        for (int k = 16; k < 4016; k++) begin
            @(posedge clk); #2;
            m_step();
            if (bus.lfsr_o !== m_state() || bus.lfsr_o === 17'h1FFFF)
                check($sformatf("lfsr_run%0d", k), 32'(bus.lfsr_o), 32'(m_state()));
            else
                n_vec++;
        end

        // Hold with lfsr_ce low.
        bus.lfsr_ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            check("lfsr_hold", 32'(bus.lfsr_o), 32'(m_state()));
        end

        // Restart beats the step enable.
        bus.cyc = 1'b1; bus.lfsr_ce = 1'b1;
        @(posedge clk); #2;
        check("lfsr_cyc", 32'(bus.lfsr_o), 32'd0);
        check("rway_cyc", 32'(bus.rway), 32'd0);
        bus.cyc = 1'b0; bus.lfsr_ce = 1'b0;

        // Full period of the reference stream, computed in zero time.
        m_clear();
        period = 0; saw_ones = 1'b0;
        do begin
            m_step();
            period++;
            if (m_state() == 17'h1FFFF) saw_ones = 1'b1;
        end while (m_state() != 17'h0 && period < 140000);
        check("model_period", 32'(period), 32'd131071);
        check("model_no_lockup", 32'(saw_ones), 32'd0);

        // Randomized run against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bus.ce      = ($urandom_range(0, 9) < 7);
            bus.lfsr_ce = $urandom_range(0, 1);
            bus.cyc     = ($urandom_range(0, 15) == 0);
            bus.i       = 9'($urandom_range(0, 3)) << ($urandom_range(0, 1) * 7);
            #1;
            check("rnd_cd", 32'(bus.cd), 32'(bus.i != m_hold));
            check("rnd_cd_d1", 32'(bus.cd_d1), 32'(m_d1));
            check("rnd_cd_first", 32'(bus.cd_first), 32'(m_d1 && !m_d1_last));
            check("rnd_lfsr", 32'(bus.lfsr_o), 32'(m_state()));
            check("rnd_rway", 32'(bus.rway), 32'(m_state() % WAYS));
            m_d1_last = m_d1;
            if (bus.ce) begin
                m_d1   = (bus.i != m_hold);
                m_hold = bus.i;
            end
            if (bus.cyc) m_clear();
            else if (bus.lfsr_ce) m_step();
            @(posedge clk); #2;
        end

        // Asynchronous reset in the middle of a cycle.
        bus.ce = 1'b1; bus.lfsr_ce = 1'b1; bus.cyc = 1'b0;
        bus.i = m_hold ^ 9'h001;
        @(posedge clk); #2;
        check("pre_rst_cd_d1", 32'(bus.cd_d1), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_lfsr", 32'(bus.lfsr_o), 32'd0);
        check("arst_cd_d1", 32'(bus.cd_d1), 32'd0);
        check("arst_cd_first", 32'(bus.cd_first), 32'd0);
        check("arst_rway", 32'(bus.rway), 32'd0);
        bus.i = 9'h005;
        #1;
        check("arst_cd", 32'(bus.cd), 32'd1);
        #3;
        rst = 1'b1;
        bus.ce = 1'b0;
        #1;
        check("rel_cd", 32'(bus.cd), 32'd1);
        @(posedge clk); #2;
        check("rel_lfsr", 32'(bus.lfsr_o), 32'd1);
        check("rel_cd_stall", 32'(bus.cd), 32'd1);
        check("rel_cd_d1", 32'(bus.cd_d1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_index_monitor.md
Name: cache_index_monitor

Overview:
- Support block for the L1 data cache. Bundles three functions:
  - change detector on the cache set index, plus a one-cycle-delayed copy of the change flag;
  - first-cycle pulse derived from the delayed flag, which qualifies victim dump decisions;
  - 17-bit LFSR pseudo-random source used for replacement-way selection.
- Single clock domain. Pure control logic; no memories.

Parameters:
- WID, 9: width of the monitored index input.
- WAYS, 4: number of cache ways. Must be a power of 2, at least 2.
- LOG_WAYS, $clog2(WAYS): width of the way-select output (derived; not overridable).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable for the change-detect and delay stages.
- lfsr_ce  in  1  clock enable for the LFSR.
- cyc  in  1  LFSR restart request (synchronous).
- i  in  WID  monitored index value.
- cd  out  1  change detect (combinational).
- cd_d1  out  1  cd delayed one cycle.
- cd_first  out  1  rising-edge pulse of cd_d1.
- lfsr_o  out  17  LFSR state.
- rway  out  LOG_WAYS  replacement way, equal to lfsr_o[LOG_WAYS-1:0].

Behaviour:
- Reset (rst=0, asynchronous, overrides everything):
  - hold register = 0, cd_d1 = 0, cd_d2 = 0, LFSR state = 0.
  - While in reset: cd = (i != 0), cd_d1 = 0, cd_first = 0, lfsr_o = 0, rway = 0.
- Change detect:
  - hold register: on clk, if ce then hold <= i, otherwise hold keeps its value.
  - cd = (i != hold). Combinational, same-cycle; it does not depend on ce.
  - A held input gives cd=1 for exactly one cycle after a change when ce=1.
  - With ce=0, cd stays 1 until ce is reasserted.
- Delay stage: on clk, if ce then cd_d1 <= cd, otherwise it holds. Latency is exactly 1 enabled cycle.
- First-cycle pulse:
  - cd_d2 <= cd_d1 every clk, ungated by ce.
  - cd_first = cd_d1 & ~cd_d2, combinational.
  - Back-to-back index changes keep cd_d1 high, so cd_first fires only on the first cycle.
- LFSR:
  - State s[16:0]. Feedback f = ~(s[16] ^ s[13]), XNOR form, taps 17 and 14.
  - Update priority on clk:
    - if cyc: s <= 0 (takes priority over lfsr_ce);
    - else if lfsr_ce: s <= {s[15:0], f};
    - else hold.
  - From 0, the state for steps k = 1..14 is 2^k-1, i.e. 0x00001, 0x00003 … 0x03FFF. Step 15 gives 0x07FFE.
  - Period is 131071 (maximal length). All-ones (0x1FFFF) is the lockup state and is never reached from reset.
  - lfsr_o = s. rway = s[LOG_WAYS-1:0]; all outputs are registered except cd and cd_first.
- Simultaneous events:
  - ce=0 freezes hold and cd_d1 but not cd_d2. cd_first therefore falls one cycle after cd_d1 rises, even when stalled.
  - Reset asserted mid-sequence clears all state immediately. The LFSR restarts from 0 on release.

Test Plan:
1. Reset, then ce=1, i=0 steady → cd=0, cd_d1=0, cd_first=0 for 10 cycles. Step i=0x1A5 → cd=1 in that cycle only; cd_d1=1 and cd_first=1 on the next cycle; all return to 0 on the cycle after.
2. ce=1, i changes every cycle 0x001,0x002,0x003,0x004 → cd=1 on each of the 4 cycles; cd_d1=1 for 4 cycles starting one cycle later; cd_first=1 only on its first cycle.
3. ce=0, i changes 0x000→0x010 → cd stays 1 and cd_d1 stays 0 while ce=0. Raise ce → hold captures 0x010, cd_d1=1 next cycle, cd=0 after capture.
4. Reset, lfsr_ce=1, cyc=0 → lfsr_o steps 0x00001, 0x00003, 0x00007 … step 14 = 0x03FFF, step 15 = 0x07FFE. rway follows the low 2 bits (WAYS=4).
5. Run LFSR 131071 steps from 0 → returns to 0 exactly at step 131071 and never shows 0x1FFFF. lfsr_ce=0 holds the value. cyc=1 with lfsr_ce=1 → next state 0.
6. Assert rst=0 asynchronously mid-run (between clock edges) → lfsr_o, cd_d1 and cd_first go to 0 immediately, without waiting for a clock edge. After release with i=0x005 → cd=1 (hold=0).
